// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
// -----------------------------------------------------------------------------
// Sequencer between the multi-cycle control unit and the divider for div/divu.
// On an accepted request it latches the operands, holds the divider's
// level-sensitive start high until ready, then commits the quotient to LO and
// the remainder to HI. A divide by zero raises a one-cycle exception pulse and
// leaves HI/LO alone. mthi/mtlo writes are accepted only while idle.
//
// Optional feature macro: HILO_DIV_TIMEOUT_EN
//   Defined   : an 8-bit watchdog aborts a RUN phase after TIMEOUT_CYCLES
//               cycles without div_ready and pulses timeout_err.
//   Undefined : no watchdog, timeout_err is tied low, RUN waits indefinitely.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   div_req, rs_val/rt_val divide request and operands (sampled in IDLE)
//   hi_we, lo_we, wdata   mthi/mtlo write strobes and data
//   div_start, div_a/b    to the divider (operands stable while busy)
//   div_hi/lo/ready/zero  from the divider
//   hi_out, lo_out        architectural HI/LO
//   busy, done, div0_exc, timeout_err   status; the last three are pulses
//   dbg_state             current FSM state for observation
//
// Handshake: the divider runs while div_start is high and raises div_ready
// when its outputs are valid; it clears div_ready one edge after div_start
// drops. The controller only accepts a new divide once div_ready reads 0,
// so a stale ready from a previous (or un-reset) divide is never consumed.
// -----------------------------------------------------------------------------
module hilo_div_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        div_req,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_ready,
    input  logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div0_exc,
    output logic        timeout_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e state_q;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("hilo_div_ctrl: TIMEOUT_CYCLES must be in 2..255");
        end
    endgenerate

`ifdef HILO_DIV_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    // Abort on the edge where the count of completed RUN cycles reaches the limit.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
`else
    assign timeout_err = 1'b0;
`endif

    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            div_start   <= 1'b0;
            div_a       <= '0;
            div_b       <= '0;
            hi_out      <= '0;
            lo_out      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div0_exc    <= 1'b0;
`ifdef HILO_DIV_TIMEOUT_EN
            timeout_err <= 1'b0;
            tmo_cnt_q   <= '0;
`endif
        end else begin
            // Status pulses default low; set for exactly one cycle below.
            done     <= 1'b0;
            div0_exc <= 1'b0;
`ifdef HILO_DIV_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // mthi/mtlo land first; a divide accepted on the same edge
                    // commits later and overwrites.
                    if (hi_we) hi_out <= wdata;
                    if (lo_we) lo_out <= wdata;
                    // div_ready high here is stale output; hold the request off.
                    if (div_req && !div_ready) begin
                        div_a     <= rs_val;
                        div_b     <= rt_val;
                        div_start <= 1'b1;
                        busy      <= 1'b1;
                        state_q   <= RUN;
`ifdef HILO_DIV_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                RUN: begin
                    if (div_ready) begin
                        div_start <= 1'b0;
                        state_q   <= DRAIN;
                        if (div_zero) begin
                            div0_exc <= 1'b1;
                        end else begin
                            lo_out <= div_lo;
                            hi_out <= div_hi;
                            done   <= 1'b1;
                        end
                    end
`ifdef HILO_DIV_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        div_start   <= 1'b0;
                        timeout_err <= 1'b1;
                        state_q     <= DRAIN;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                DRAIN: begin
                    // Wait for the divider to drop ready before taking new work.
                    if (!div_ready) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    div_start <= 1'b0;
                    busy      <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
module tb_hilo_div_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        div_req = 1'b0;
    logic [31:0] rs_val = '0, rt_val = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        div_start;
    logic [31:0] div_a, div_b, hi_out, lo_out;
    logic        busy, done, div0_exc, timeout_err;
    logic [1:0]  dbg_state;

    // Divider stub: level-sensitive start, ready one edge after it sees start,
    // ready cleared one edge after start drops. Not reset by reset_n.
    logic [31:0] stub_hi = '0, stub_lo = '0;
    logic        stub_ready = 1'b0, stub_zero = 1'b0;
    bit          stub_hang = 1'b0;

    always @(posedge clk) begin
        if (!div_start) begin
            stub_ready <= 1'b0;
        end else if (!stub_hang) begin
            stub_ready <= 1'b1;
            stub_zero  <= (div_b == 32'd0);
            stub_lo    <= (div_b == 32'd0) ? 32'd0 : div_a / div_b;
            stub_hi    <= (div_b == 32'd0) ? 32'd0 : div_a % div_b;
        end
    end

    hilo_div_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .div_req(div_req),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_hi(stub_hi), .div_lo(stub_lo), .div_ready(stub_ready),
        .div_zero(stub_zero), .hi_out(hi_out), .lo_out(lo_out), .busy(busy),
        .done(done), .div0_exc(div0_exc), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_hi = '0, model_lo = '0;
    logic [63:0] exp_q[$];   // expected {hi, lo} of each non-zero divide

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Wait (bounded) for busy to rise; returns the number of negedges taken.
    task automatic wait_accept(output int n);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n++;
            hi_we = 1'b0;
            lo_we = 1'b0;
            if (busy) break;
        end
        check("accept_seen", 32'(busy), 32'd1);
    endtask

    // Called at the first negedge after acceptance; walks the 4 busy cycles.
    // wr_busy: attempt an mtlo while busy (must be ignored).
    task automatic follow_div(input logic [31:0] rs, input logic [31:0] rt, input bit wr_busy);
        logic [63:0] e;
        div_req = 1'b0;
        if (rt != 0) exp_q.push_back({rs % rt, rs / rt});
        check("c0_start", 32'(div_start), 32'd1);
        check("c0_div_a", div_a, rs);
        check("c0_div_b", div_b, rt);
        check("c0_done", 32'(done), 32'd0);
        if (wr_busy) begin
            lo_we = 1'b1;
            wdata = 32'h0000_1234;
        end
        @(negedge clk);
        lo_we = 1'b0;
        check("c1_start", 32'(div_start), 32'd1);
        check("c1_busy", 32'(busy), 32'd1);
        if (wr_busy) check("busy_write_ignored", lo_out, model_lo);
        @(negedge clk);
        check("c2_done", 32'(done), 32'(rt != 0));
        check("c2_div0_exc", 32'(div0_exc), 32'(rt == 0));
        check("c2_start", 32'(div_start), 32'd0);
        check("c2_div_a", div_a, rs);
        if (rt != 0) begin
            e = exp_q.pop_front();
            model_hi = e[63:32];
            model_lo = e[31:0];
        end
        check("c2_hi", hi_out, model_hi);
        check("c2_lo", lo_out, model_lo);
        @(negedge clk);
        check("c3_busy", 32'(busy), 32'd1);
        check("c3_done", 32'(done | div0_exc), 32'd0);
        @(negedge clk);
        check("c4_busy", 32'(busy), 32'd0);
    endtask

    // wr_mode: 0 none, 1 mtlo on the accepting edge, 2 mtlo while busy.
    task automatic do_div(input logic [31:0] rs, input logic [31:0] rt, input int wr_mode);
        int n;
        @(negedge clk);
        div_req = 1'b1;
        rs_val  = rs;
        rt_val  = rt;
        if (wr_mode == 1) begin
            lo_we = 1'b1;
            wdata = 32'h0BAD_F00D;
            model_lo = 32'h0BAD_F00D;
        end
        wait_accept(n);
        check("accept_latency", 32'(n), 32'd1);
        follow_div(rs, rt, wr_mode == 2);
    endtask

    task automatic write_hilo(input bit h, input bit l, input logic [31:0] d);
        @(negedge clk);
        hi_we = h;
        lo_we = l;
        wdata = d;
        if (h) model_hi = d;
        if (l) model_lo = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt_hi", hi_out, model_hi);
        check("mt_lo", lo_out, model_lo);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 32'(div_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pulses"}, 32'({done, div0_exc, timeout_err}), 32'd0);
        check({tag, "_div_a"}, div_a, 32'd0);
        check({tag, "_div_b"}, div_b, 32'd0);
        check({tag, "_hi"}, hi_out, 32'd0);
        check({tag, "_lo"}, lo_out, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [31:0] rs, rt;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Basic divide and divide-by-zero with preloaded HI/LO.
        do_div(32'd100, 32'd7, 0);
        write_hilo(1'b1, 1'b1, 32'hAAAA_5555);
        do_div(32'd5, 32'd0, 0);

        // Back-to-back with div_req held high across both.
        @(negedge clk);
        div_req = 1'b1;
        rs_val = 32'hFFFF_FFFF;
        rt_val = 32'h10;
        wait_accept(n);
        rs_val = 32'd9;
        rt_val = 32'd3;
        check("b2b_div_a", div_a, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        check("b2b1_done", 32'(done), 32'd1);
        check("b2b1_lo", lo_out, 32'h0FFF_FFFF);
        check("b2b1_hi", hi_out, 32'hF);
        @(negedge clk);
        check("b2b_c3_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("b2b_gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("b2b_second_accept", 32'(busy), 32'd1);
        model_hi = 32'hF;
        model_lo = 32'h0FFF_FFFF;
        follow_div(32'd9, 32'd3, 1'b0);

        // mtlo in IDLE, mtlo while busy, mtlo on the accepting edge.
        write_hilo(1'b0, 1'b1, 32'h0000_1234);
        do_div(32'd50, 32'd6, 2);
        do_div(32'd81, 32'd4, 1);
        // A zero divisor with a same-edge write keeps the written value.
        do_div(32'd3, 32'd0, 1);

        // Reset during RUN, then a request that must wait out the stale ready.
        @(negedge clk);
        div_req = 1'b1;
        rs_val = 32'd1000;
        rt_val = 32'd10;
        wait_accept(n);
        div_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        model_hi = '0;
        model_lo = '0;
        #1;
        reset_n = 1'b1;
        div_req = 1'b1;
        rs_val = 32'd77;
        rt_val = 32'd5;
        wait_accept(n);
        check("stale_ready_holdoff", 32'(n), 32'd2);
        follow_div(32'd77, 32'd5, 1'b0);

        // Randomized mix of divides and mthi/mtlo.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end else begin
                rs = $urandom;
                case ($urandom_range(0, 7))
                    0:       rt = 32'd0;
                    1, 2:    rt = $urandom;
                    default: rt = $urandom_range(1, 100);
                endcase
                do_div(rs, rt, int'($urandom_range(0, 2)));
            end
        end

        // Divider that never readies.
        stub_hang = 1'b1;
        @(negedge clk);
        div_req = 1'b1;
        rs_val = 32'd40;
        rt_val = 32'd8;
        wait_accept(n);
        div_req = 1'b0;
`ifdef HILO_DIV_TIMEOUT_EN
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            check("tmo_run_start", 32'(div_start), 32'd1);
            check("tmo_no_err_yet", 32'(timeout_err), 32'd0);
        end
        @(negedge clk);
        check("tmo_err_pulse", 32'(timeout_err), 32'd1);
        check("tmo_start_drop", 32'(div_start), 32'd0);
        check("tmo_hi", hi_out, model_hi);
        check("tmo_lo", lo_out, model_lo);
        check("tmo_done", 32'(done), 32'd0);
        @(negedge clk);
        check("tmo_err_cleared", 32'(timeout_err), 32'd0);
        check("tmo_idle", 32'(busy), 32'd0);
        stub_hang = 1'b0;
        do_div(32'd40, 32'd8, 0);
`else
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hang_busy", 32'(busy), 32'd1);
            check("hang_no_tmo", 32'(timeout_err), 32'd0);
        end
        stub_hang = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_hi = '0;
        model_lo = '0;
        repeat (2) @(negedge clk);
        do_div(32'd40, 32'd8, 0);
`endif

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Sequencer between the multi-cycle control unit and the `divider` stage for `div`/`divu`. Latches rs/rt on a request, drives the divider's level-sensitive `start`, waits for `ready`, and commits quotient/remainder into the architectural LO/HI registers. It reports divide-by-zero as a one-cycle exception pulse instead of committing. It also owns `mthi`/`mtlo` writes and exposes HI/LO for `mfhi`/`mflo`.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum RUN cycles before abort (used only with `HILO_DIV_TIMEOUT_EN`); range 2..255.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `div_req` in 1: control unit requests a divide; sampled only in IDLE.
- `rs_val` in 32: dividend, sampled with `div_req`.
- `rt_val` in 32: divisor, sampled with `div_req`.
- `hi_we` in 1: `mthi` write strobe.
- `lo_we` in 1: `mtlo` write strobe.
- `wdata` in 32: data for `hi_we`/`lo_we`.
- `div_start` out 1: to divider `start`.
- `div_a` out 32: to divider `a`; registered and stable while `busy`.
- `div_b` out 32: to divider `b`; registered and stable while `busy`.
- `div_hi` in 32: from divider `hi` (remainder).
- `div_lo` in 32: from divider `lo` (quotient).
- `div_ready` in 1: from divider `ready`.
- `div_zero` in 1: from divider `div_zero`.
- `hi_out` out 32: architectural HI register.
- `lo_out` out 32: architectural LO register.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse; HI/LO updated by a divide.
- `div0_exc` out 1: one-cycle pulse; divisor was zero and HI/LO are unchanged.
- `timeout_err` out 1: one-cycle pulse; the watchdog aborted the divide.

## Operation
- Reset values: state IDLE. `div_start`, `busy`, `done`, `div0_exc`, `timeout_err` = 0. `div_a`, `div_b`, `hi_out`, `lo_out` = 0.
- **IDLE**: on `div_req`=1 and `div_ready`=0, latch `div_a`←`rs_val` and `div_b`←`rt_val`, then go to RUN. A `div_req` seen while `div_ready`=1 (stale divider output) is held off; the control unit keeps `div_req` high until `busy` rises.
- **RUN**: `div_start`=1.
  - `div_ready`=1 and `div_zero`=0: `lo_out`←`div_lo`, `hi_out`←`div_hi`, pulse `done`, go to DRAIN.
  - `div_ready`=1 and `div_zero`=1: HI/LO untouched, pulse `div0_exc`, go to DRAIN.
- **DRAIN**: `div_start`=0. Go to IDLE on the first edge that samples `div_ready`=0.
- `hi_we`/`lo_we`: write `wdata` at the edge, only when state is IDLE; ignored when `busy`. When `hi_we`/`lo_we` and `div_req` are accepted on the same edge, the write lands first and the later divide result overwrites it.
- `div_req` outside IDLE is ignored; no queueing.
- Reset asserted mid-operation: return to reset values immediately (async). The `div_ready`=0 gate in IDLE absorbs the divider's un-reset `ready`.

## Timing
- `div_req` is sampled at edge N.
- `div_start` is high after N. The divider sees it at N+1, and `div_ready` is high after N+1.
- Commit or exception happens at N+2. `done`/`div0_exc` are high for one cycle, N+2→N+3.
- `div_start` is low after N+2. The divider clears `ready` at N+3; the controller samples `div_ready`=0 at N+4 and returns to IDLE.
- `busy` is high from after N until N+4, a total of 4 cycles.
- The earliest next accepted `div_req` is at N+5.
- `hi_out`/`lo_out` are readable by `mfhi`/`mflo` on the cycle `done` is high.
- `div_a`/`div_b` never change while `busy`=1.

## Configuration
- Macro: `HILO_DIV_TIMEOUT_EN`.
- Defined: an 8-bit counter clears on entry to RUN and increments every RUN cycle. If it reaches `TIMEOUT_CYCLES` with `div_ready`=0:
  - drop `div_start`;
  - pulse `timeout_err`;
  - leave HI/LO unchanged;
  - go to DRAIN.
- A `div_ready` on the same edge as the timeout wins: normal commit, no `timeout_err`.
- Undefined: no counter; `timeout_err` is tied to 0; RUN waits indefinitely.

## Test plan
- Reset, then `div_req` with rs=100, rt=7 → `div_start` high for 2 cycles; `lo_out`=14 and `hi_out`=2 at N+2; `done` 1-cycle pulse; `busy` for 4 cycles.
- rs=5, rt=0 → `div0_exc` pulse at N+2; `done`=0; HI/LO keep their prior values (preload via `hi_we`/`lo_we`=0xAAAA5555).
- Back-to-back: hold `div_req` high with rs=0xFFFFFFFF, rt=0x10, then rs=9, rt=3 → results 0x0FFFFFFF/0xF, then 3/0; second accept no earlier than N+5.
- `lo_we`=1, `wdata`=0x1234 while `busy` → ignored. Same write in IDLE → `lo_out`=0x1234 next cycle. Write plus `div_req` on the same edge → divide result overwrites.
- `reset_n` low during RUN → all outputs 0 at once. Model the divider's `ready` staying high one cycle after reset: `div_req` is held off until it clears, then completes correctly.
- With `HILO_DIV_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, divider stub never readies → `timeout_err` pulse after 4 RUN cycles; HI/LO unchanged; back to IDLE. Without the macro, `busy` stays high.
